// File: rtl/fixed_point_issue_controller_pkg.sv
// Shared encodings for the fixed-point issue controller: FPU op codes and FSM states.
package fixed_point_issue_controller_pkg;

   localparam int unsigned FPU_OP_W = 2;

   localparam logic [FPU_OP_W-1:0] FPU_ADD  = 2'b00;
   localparam logic [FPU_OP_W-1:0] FPU_SUB  = 2'b01;
   localparam logic [FPU_OP_W-1:0] FPU_MUL  = 2'b10;
   localparam logic [FPU_OP_W-1:0] FPU_SQRT = 2'b11;

   // Neutral op driven between requests so the FPU's MUL/SQRT stage counters restart.
   localparam logic [FPU_OP_W-1:0] FPU_IDLE_OP = FPU_ADD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } issue_state_e;

endpackage

// File: rtl/fixed_point_issue_controller_fpu_timeout_counter.sv
// EXEC-phase watchdog: counts enabled cycles and flags when LIMIT cycles have elapsed.
module fixed_point_issue_controller_fpu_timeout_counter #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_c_o
);

   localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Expiry is reported during the LIMIT-th enabled cycle so the FSM leaves on that edge.
   assign expired_c_o = enable_i && (count_q == CW'(LIMIT - 1));

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_c_o) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fixed_point_issue_controller.sv
// Issue sequencer in front of the Fixed_Point_Unit: holds one op stable, captures its result, hands it to writeback.
// Optional watchdog enabled by defining FPU_TIMEOUT_EN.
module fixed_point_issue_controller
   import fixed_point_issue_controller_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned TAG_WIDTH      = 5,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_operation,
   input  logic [WIDTH-1:0]     in_operand_1,
   input  logic [WIDTH-1:0]     in_operand_2,
   input  logic [TAG_WIDTH-1:0] in_tag,
   output logic [1:0]           fpu_operation,
   output logic [WIDTH-1:0]     fpu_operand_1,
   output logic [WIDTH-1:0]     fpu_operand_2,
   input  logic [WIDTH-1:0]     fpu_result,
   input  logic                 fpu_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_result,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_error
);

   issue_state_e         state_q, state_d;
   logic                 in_ready_q, in_ready_d;
   logic [1:0]           fpu_op_q, fpu_op_d;
   logic [WIDTH-1:0]     opnd1_q, opnd1_d;
   logic [WIDTH-1:0]     opnd2_q, opnd2_d;
   logic [TAG_WIDTH-1:0] tag_q, tag_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     out_result_q, out_result_d;
   logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
   logic                 out_error_q, out_error_d;
   logic                 timeout_c;

`ifdef FPU_TIMEOUT_EN
   fixed_point_issue_controller_fpu_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (state_q != ST_EXEC),
      .enable_i    (state_q == ST_EXEC),
      .expired_c_o (timeout_c)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_c          = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      in_ready_d   = in_ready_q;
      fpu_op_d     = fpu_op_q;
      opnd1_d      = opnd1_q;
      opnd2_d      = opnd2_q;
      tag_d        = tag_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
      out_error_d  = out_error_q;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d    = ST_EXEC;
               in_ready_d = 1'b0;
               fpu_op_d   = in_operation;
               opnd1_d    = in_operand_1;
               opnd2_d    = in_operand_2;
               tag_d      = in_tag;
            end
         end
         ST_EXEC: begin
            // A real ready wins over a watchdog expiry in the same cycle.
            if (fpu_ready) begin
               state_d      = ST_RESP;
               fpu_op_d     = FPU_IDLE_OP;
               out_valid_d  = 1'b1;
               out_result_d = fpu_result;
               out_tag_d    = tag_q;
               out_error_d  = 1'b0;
            end else if (timeout_c) begin
               state_d      = ST_RESP;
               fpu_op_d     = FPU_IDLE_OP;
               out_valid_d  = 1'b1;
               out_result_d = '0;
               out_tag_d    = tag_q;
               out_error_d  = 1'b1;
            end
         end
         ST_RESP: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               out_error_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            fpu_op_d    = FPU_IDLE_OP;
            out_valid_d = 1'b0;
            out_error_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         in_ready_q   <= 1'b1;
         fpu_op_q     <= FPU_IDLE_OP;
         opnd1_q      <= '0;
         opnd2_q      <= '0;
         tag_q        <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_tag_q    <= '0;
         out_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         fpu_op_q     <= fpu_op_d;
         opnd1_q      <= opnd1_d;
         opnd2_q      <= opnd2_d;
         tag_q        <= tag_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
         out_error_q  <= out_error_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign fpu_operation = fpu_op_q;
   assign fpu_operand_1 = opnd1_q;
   assign fpu_operand_2 = opnd2_q;
   assign out_valid     = out_valid_q;
   assign out_result    = out_result_q;
   assign out_tag       = out_tag_q;
   assign out_error     = out_error_q;

endmodule

// File: tb/tb_fixed_point_issue_controller.sv
// Bench for fixed_point_issue_controller with a behavioural Q22.10 FPU stub; define FPU_TIMEOUT_EN to exercise the watchdog.
module tb_fixed_point_issue_controller;
   import fixed_point_issue_controller_pkg::*;

   localparam int unsigned WIDTH          = 32;
   localparam int unsigned TAG_WIDTH      = 5;
   localparam int unsigned TIMEOUT_CYCLES = 8;
   localparam int          BUDGET         = 200;
   // Cycles the stub FPU spends in its stage counter before MUL pulses / SQRT levels ready.
   localparam int unsigned MUL_STAGES     = 5;
   localparam int unsigned SQRT_STAGES    = 23;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           in_operation;
   logic [WIDTH-1:0]     in_operand_1;
   logic [WIDTH-1:0]     in_operand_2;
   logic [TAG_WIDTH-1:0] in_tag;
   logic [1:0]           fpu_operation;
   logic [WIDTH-1:0]     fpu_operand_1;
   logic [WIDTH-1:0]     fpu_operand_2;
   logic [WIDTH-1:0]     fpu_result;
   logic                 fpu_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_result;
   logic [TAG_WIDTH-1:0] out_tag;
   logic                 out_error;

   int checks = 0;
   int errors = 0;
   int unsigned stage_q = 0;
   logic stuck = 1'b0;

   fixed_point_issue_controller #(
      .WIDTH          (WIDTH),
      .TAG_WIDTH      (TAG_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_operation  (in_operation),
      .in_operand_1  (in_operand_1),
      .in_operand_2  (in_operand_2),
      .in_tag        (in_tag),
      .fpu_operation (fpu_operation),
      .fpu_operand_1 (fpu_operand_1),
      .fpu_operand_2 (fpu_operand_2),
      .fpu_result    (fpu_result),
      .fpu_ready     (fpu_ready),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_tag       (out_tag),
      .out_error     (out_error)
   );

   always #5 clk = ~clk;

   // Fixed-point arithmetic with 10 fractional bits, as the FPU computes it.
   function automatic logic [31:0] ref_fpu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      logic [63:0] rad, r, t;
      case (op)
         FPU_ADD: return a + b;
         FPU_SUB: return a - b;
         FPU_MUL: begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            p  = sa * sb;
            return p[41:10];
         end
         default: begin
            rad = {32'd0, a} << 10;
            r   = 64'd0;
            for (int i = 31; i >= 0; i--) begin
               t = r | (64'd1 << i);
               if (t * t <= rad) r = t;
            end
            return r[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] op);
      if (op == FPU_MUL)  return 7;
      if (op == FPU_SQRT) return 25;
      return 2;
   endfunction

   // Stub FPU: MUL/SQRT stage counter runs only while that op is held, restarts on any other op.
   always @(posedge clk) begin
      if (fpu_operation == FPU_MUL || fpu_operation == FPU_SQRT) stage_q <= stage_q + 1;
      else stage_q <= 0;
   end

   always_comb begin
      fpu_ready = 1'b0;
      if (!stuck) begin
         case (fpu_operation)
            FPU_MUL:  fpu_ready = (stage_q == MUL_STAGES);
            FPU_SQRT: fpu_ready = (stage_q >= SQRT_STAGES);
            default:  fpu_ready = 1'b1;
         endcase
      end
   end

   assign fpu_result = ref_fpu(fpu_operation, fpu_operand_1, fpu_operand_2);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits for in_ready, presents one op, returns at the negedge right after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_issue", 64'(in_ready), 64'd1);
      in_valid     = 1'b1;
      in_operation = op;
      in_operand_1 = a;
      in_operand_2 = b;
      in_tag       = tag;
      @(negedge clk);
      in_valid     = 1'b0;
      in_operation = 2'($urandom);
      in_operand_1 = $urandom;
      in_operand_2 = $urandom;
      in_tag       = 5'($urandom);
      check("exec_operation", 64'(fpu_operation), 64'(op));
      check("exec_operand_1", 64'(fpu_operand_1), 64'(a));
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold, input logic [31:0] exp);
      int   n;
      logic saw_ready, stable;
      issue(op, a, b, tag);
      n = 1;
      saw_ready = in_ready;
      while (out_valid !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
         saw_ready |= in_ready;
         // Offer another op mid-flight; it must not be taken.
         in_valid = 1'($urandom);
      end
      in_valid = 1'b0;
      check("latency", 64'(n), 64'(ref_latency(op)));
      check("in_ready_busy", 64'(saw_ready), 64'd0);
      check("out_result", 64'(out_result), 64'(exp));
      check("out_tag", 64'(out_tag), 64'(tag));
      check("out_error", 64'(out_error), 64'd0);
      check("resp_neutral_op", 64'(fpu_operation), 64'(FPU_ADD));
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         if (out_valid !== 1'b1 || out_result !== exp || out_tag !== tag || in_ready !== 1'b0) stable = 1'b0;
      end
      in_valid = 1'b0;
      if (hold > 0) check("resp_hold_stable", 64'(stable), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_hs_out_valid", 64'(out_valid), 64'd0);
      check("post_hs_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      int   n;
      logic saw_valid, saw_err;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_operation = FPU_ADD; in_operand_1 = '0; in_operand_2 = '0; in_tag = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_result", 64'(out_result), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_out_error", 64'(out_error), 64'd0);
      check("rst_fpu_op", 64'(fpu_operation), 64'(FPU_ADD));
      check("rst_fpu_opnds", {fpu_operand_1, fpu_operand_2}, 64'd0);

      do_op(FPU_ADD, 32'h600, 32'h900, 5'd3, 0, 32'h0000_0F00);
      do_op(FPU_MUL, 32'h600, 32'h600, 5'd4, 0, 32'h0000_0900);
      do_op(FPU_MUL, 32'h800, 32'hC00, 5'd5, 0, 32'h0000_1800);
      do_op(FPU_SQRT, 32'h1000, 32'hDEAD, 5'd6, 5, 32'h0000_0800);
      do_op(FPU_SUB, 32'h400, 32'h800, 5'd7, 1, 32'hFFFF_FC00);

      // Reset during the 10th EXEC cycle of a SQRT abandons it.
      issue(FPU_SQRT, 32'h1000, 32'h0, 5'd9);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_fpu_op", 64'(fpu_operation), 64'(FPU_ADD));
      do_op(FPU_ADD, 32'h1234, 32'h0FF0, 5'd10, 0, 32'h0000_2224);

      for (int k = 0; k < 20; k++) begin
         rop = 2'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         if (rop == FPU_SQRT) ra = $urandom_range(0, 32'h003F_FFFF);
         do_op(rop, ra, rb, 5'($urandom), int'($urandom_range(0, 3)), ref_fpu(rop, ra, rb));
      end

      stuck = 1'b1;
      issue(FPU_MUL, 32'h400, 32'h400, 5'd12);
`ifdef FPU_TIMEOUT_EN
      n = 1;
      while (out_valid !== 1'b1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("timeout_latency", 64'(n), 64'(TIMEOUT_CYCLES + 1));
      check("timeout_error", 64'(out_error), 64'd1);
      check("timeout_result", 64'(out_result), 64'd0);
      check("timeout_tag", 64'(out_tag), 64'd12);
      check("timeout_neutral_op", 64'(fpu_operation), 64'(FPU_ADD));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("timeout_error_clear", 64'(out_error), 64'd0);
      check("timeout_in_ready", 64'(in_ready), 64'd1);
`else
      saw_valid = 1'b0;
      saw_err   = 1'b0;
      repeat (100) begin
         @(negedge clk);
         saw_valid |= out_valid;
         saw_err   |= out_error;
      end
      check("stuck_no_valid", 64'(saw_valid), 64'd0);
      check("stuck_no_error", 64'(saw_err), 64'd0);
      check("stuck_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`endif
      stuck = 1'b0;
      do_op(FPU_MUL, 32'hFFFF_F800, 32'h600, 5'd13, 0, 32'hFFFF_F400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
